// File: rtl/keyboard_controller.sv
// keyboard_controller
// -------------------
// PS/2 keyboard receiver. The asynchronous PS/2 clock and data pins are
// brought into the clk domain through equal-length synchronizer chains. The
// block detects falling edges of the synchronized PS/2 clock and deframes
// 11-bit device-to-host frames:
//   start(0), data[0..7] (LSB first), odd parity, stop(1).
// The most recent good byte is held on char.
//
// Ports
//   clk       in   system clock; all logic uses the rising edge
//   rst       in   synchronous active-high reset
//   ps2_clk   in   raw PS/2 clock (asynchronous, idle high)
//   ps2_data  in   raw PS/2 data  (asynchronous, idle high)
//   char      out  last accepted byte (scan code), held until the next one
//   valid     out  one-clk pulse when char is updated
//   err       out  one-clk pulse on a rejected frame (start/parity/stop/timeout)
//
// Parameters
//   SYNC_STAGES     flops per input synchronizer (>= 2)
//   TIMEOUT_CYCLES  clks without a PS/2 falling edge mid-frame before abandon
//
// Optional build macro
//   BREAK_FILTER_EN  when defined, break (F0) and extended (E0) prefixes and
//                    the byte following F0 are consumed internally, so only
//                    make codes reach char/valid.
//
// Latency: char/valid update SYNC_STAGES+2 clks after the raw ps2_clk fall
// that carries the stop bit.

module keyboard_controller #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] char,
  output logic       valid,
  output logic       err
);

  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   fall_p0;
  logic                   fall_p1;
  logic                   data_p1;

  logic [1:0]      state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            par_bit;
  logic [TO_W-1:0] to_cnt;
`ifdef BREAK_FILTER_EN
  logic            brk;
`endif

  // Stage p0: synchronizers, then edge detect on the synchronized clock.
  // Both chains share the same depth so data stays aligned with the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall_p0 = clk_prev & ~clk_sync[SYNC_STAGES-1];

  // Stage p1: registered edge strobe with the data sample taken alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      fall_p1 <= 1'b0;
      data_p1 <= 1'b1;
    end else begin
      fall_p1 <= fall_p0;
      data_p1 <= data_sync[SYNC_STAGES-1];
    end
  end

  // Stage p2: frame FSM, timeout and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
      par_bit <= 1'b0;
      to_cnt  <= '0;
      char    <= 8'h00;
      valid   <= 1'b0;
      err     <= 1'b0;
`ifdef BREAK_FILTER_EN
      brk     <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      if (state == IDLE) begin
        to_cnt <= '0;
        // A fall with data high is line noise / idle; ignore silently.
        if (fall_p1 && !data_p1) begin
          state   <= DATA;
          bit_cnt <= 3'd0;
          shift   <= 8'h00;
        end
      end else if (fall_p1) begin
        to_cnt <= '0;
        case (state)
          DATA: begin
            shift   <= {data_p1, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= data_p1;
            state   <= STOP;
          end
          default: begin
            state <= IDLE;
            // Odd parity over data+parity, and a high stop bit.
            if (data_p1 && (^{shift, par_bit})) begin
`ifdef BREAK_FILTER_EN
              if (shift == 8'hF0) begin
                brk <= 1'b1;
              end else if (shift != 8'hE0) begin
                if (brk) begin
                  // Key-release code: swallow it and re-arm.
                  brk <= 1'b0;
                end else begin
                  char  <= shift;
                  valid <= 1'b1;
                end
              end
`else
              char  <= shift;
              valid <= 1'b1;
`endif
            end else begin
              err <= 1'b1;
            end
          end
        endcase
      end else if (to_cnt == TO_LAST) begin
        // Keyboard stalled mid-frame: drop the partial byte.
        err     <= 1'b1;
        state   <= IDLE;
        bit_cnt <= 3'd0;
        shift   <= 8'h00;
        to_cnt  <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_keyboard_controller.sv
// Bench for keyboard_controller: table of whole frames with expected
// char / valid-count / err-count, plus hand-written sequences for latency,
// timeout and reset mid-frame. Built with TIMEOUT_CYCLES=50.

module tb_keyboard_controller;

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] char;
  logic       valid;
  logic       err;

  keyboard_controller #(
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .char(char),
    .valid(valid),
    .err(err)
  );

  // 40 ns system clock
  initial clk = 1'b0;
  always #20 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int vcnt   = 0;
  int ecnt   = 0;
  int both   = 0;

  always @(negedge clk) begin
    if (valid) vcnt++;
    if (err) ecnt++;
    if (valid && err) both++;
  end

  typedef struct {
    logic [7:0] d;
    bit         par_ok;
    bit         stop;
    logic [7:0] exp_char;
    int         exp_v;
    int         exp_e;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive the first nfall bits of a frame; each bit is 1 clk high then
  // 1 clk low (80 ns PS/2 period). Returns with ps2_clk low just after
  // the last falling edge was driven (on a negedge of clk).
  task automatic send_bits(input logic [7:0] d, input bit par_ok,
                           input bit stop, input int nfall);
    logic [10:0] bits;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    bits[9]   = par_ok ? ~(^d) : (^d);
    bits[10]  = stop;
    for (int i = 0; i < nfall; i++) begin
      @(negedge clk);
      ps2_clk  = 1'b1;
      ps2_data = bits[i];
      @(negedge clk);
      ps2_clk  = 1'b0;
    end
  endtask

  task automatic release_lines();
    @(negedge clk);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
  endtask

  task automatic check_frame(input string name, input vec_t v);
    int v0;
    int e0;
    v0 = vcnt;
    e0 = ecnt;
    send_bits(v.d, v.par_ok, v.stop, 11);
    release_lines();
    repeat (10) @(negedge clk);
    chk({name, " char"}, int'(char), int'(v.exp_char));
    chk({name, " valid pulses"}, vcnt - v0, v.exp_v);
    chk({name, " err pulses"}, ecnt - e0, v.exp_e);
  endtask

  initial begin
    int v0;
    int e0;
    vec_t v;

    tbl[0] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1, 0};
    tbl[1] = '{8'h1C, 1'b1, 1'b1, 8'h1C, 1, 0};
    tbl[2] = '{8'h32, 1'b0, 1'b1, 8'h1C, 0, 1};  // wrong parity
    tbl[3] = '{8'h23, 1'b1, 1'b0, 8'h1C, 0, 1};  // stop bit low
    tbl[4] = '{8'h23, 1'b1, 1'b1, 8'h23, 1, 0};
    tbl[5] = '{8'h1C, 1'b1, 1'b1, 8'h1C, 1, 0};
`ifdef BREAK_FILTER_EN
    tbl[6] = '{8'hF0, 1'b1, 1'b1, 8'h1C, 0, 0};
    tbl[7] = '{8'h1C, 1'b1, 1'b1, 8'h1C, 0, 0};
`else
    tbl[6] = '{8'hF0, 1'b1, 1'b1, 8'hF0, 1, 0};
    tbl[7] = '{8'h1C, 1'b1, 1'b1, 8'h1C, 1, 0};
`endif

    // Reset with idle lines
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset char", int'(char), 0);
    chk("reset valid", int'(valid), 0);
    chk("reset err", int'(err), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      check_frame($sformatf("vec%0d", i), tbl[i]);
    end

    // Timeout: start + 4 data bits, then ps2_clk stays high
    v0 = vcnt;
    e0 = ecnt;
    send_bits(8'h45, 1'b1, 1'b1, 5);
    release_lines();
    repeat (40) @(negedge clk);
    chk("timeout early err", ecnt - e0, 0);
    repeat (20) @(negedge clk);
    chk("timeout err", ecnt - e0, 1);
    chk("timeout valid", vcnt - v0, 0);
    v = '{8'h45, 1'b1, 1'b1, 8'h45, 1, 0};
    check_frame("after timeout", v);

    // Latency and pulse width: valid appears on the 4th posedge after
    // the raw stop-bit fall (SYNC_STAGES+2) and lasts one clk.
    send_bits(8'h5A, 1'b1, 1'b1, 11);
    @(posedge clk);
    #1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("latency valid before", int'(valid), 0);
    @(posedge clk);
    #1;
    chk("latency valid at", int'(valid), 1);
    chk("latency char", int'(char), 8'h5A);
    @(posedge clk);
    #1;
    chk("latency valid after", int'(valid), 0);
    repeat (4) @(negedge clk);

    // Reset mid-frame, then a fresh frame
    e0 = ecnt;
    send_bits(8'h66, 1'b1, 1'b1, 4);
    release_lines();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst char", int'(char), 0);
    chk("midrst err", ecnt - e0, 0);
    v = '{8'h29, 1'b1, 1'b1, 8'h29, 1, 0};
    check_frame("after midrst", v);

    chk("valid and err overlap", both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
